// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-clock time-entry logic: FSM encoding,
// BCD digit limits and the entry-validity check.
package alarm_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ST_ENTRY      = 3'd1;
  localparam logic [STATE_W-1:0] ST_SHOW_ALARM = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOAD_TIME  = 3'd3;
  localparam logic [STATE_W-1:0] ST_LOAD_ALARM = 3'd4;

  localparam logic [3:0] MS_HR_MAX     = 4'd2;
  localparam logic [3:0] LS_HR_MAX_TOP = 4'd3;
  localparam logic [3:0] MS_MIN_MAX    = 4'd5;
  localparam logic [3:0] DIGIT_MAX     = 4'd9;

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= DIGIT_MAX;
  endfunction

  // 24-hour HH:MM check; hours 20-23 restrict the second hour digit.
  function automatic logic entry_valid(input bcd_time_t t);
    logic hr_ok;
    hr_ok = (t.ms_hr == MS_HR_MAX) ? (t.ls_hr <= LS_HR_MAX_TOP) : (t.ls_hr <= DIGIT_MAX);
    return (t.ms_hr <= MS_HR_MAX) && hr_ok && (t.ms_min <= MS_MIN_MAX) && (t.ls_min <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Keypad/button inputs and display/load outputs of the time-set controller.
interface time_set_ctrl_if;
  logic       one_second;
  logic       key_valid;
  logic [3:0] key;
  logic       time_button;
  logic       alarm_button;
  logic [3:0] new_time_ms_hr;
  logic [3:0] new_time_ls_hr;
  logic [3:0] new_time_ms_min;
  logic [3:0] new_time_ls_min;
  logic       load_new_c;
  logic       load_new_a;
  logic       show_new_time;
  logic       show_a;
  logic       entry_err;

  modport master (
    output one_second, key_valid, key, time_button, alarm_button,
    input  new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min,
    input  load_new_c, load_new_a, show_new_time, show_a, entry_err
  );

  modport slave (
    input  one_second, key_valid, key, time_button, alarm_button,
    output new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min,
    output load_new_c, load_new_a, show_new_time, show_a, entry_err
  );
endinterface

// File: rtl/time_digit_shreg.sv
// Four-digit BCD entry register: keys enter at ls_min and shift toward ms_hr.
module time_digit_shreg
  import alarm_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      shift,
  input  logic [3:0] key,
  output bcd_time_t digits
);

  bcd_time_t digits_q, digits_d;

  // A clear with shift starts a fresh entry holding only the new key.
  always_comb begin
    digits_d = digits_q;
    if (shift) begin
      digits_d = clear ? bcd_time_t'({12'h000, key}) : bcd_time_t'({digits_q[11:0], key});
    end else if (clear) begin
      digits_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) digits_q <= '0;
    else       digits_q <= digits_d;
  end

  assign digits = digits_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad time/alarm entry controller: collects four BCD digits, validates them
// and issues one-cycle load pulses for the current time or alarm.
module time_set_ctrl
  import alarm_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input logic            clk,
  input logic            reset,
  time_set_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_S + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_S);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d, tmr_inc;
  logic               load_c_q, load_c_d, load_a_q, load_a_d;
  logic               show_new_q, show_new_d, show_a_q, show_a_d;
  logic               err_q, err_d;
  logic               sh_clear, sh_shift, key_digit, valid;
  bcd_time_t          digits;

  time_digit_shreg u_shreg (
    .clk    (clk),
    .reset  (reset),
    .clear  (sh_clear),
    .shift  (sh_shift),
    .key    (bus.key),
    .digits (digits)
  );

  assign key_digit = bus.key_valid && is_digit(bus.key);
  assign valid     = entry_valid(digits);

  // Priority within a cycle: time_button, then alarm_button, then a digit key,
  // then the one-second tick.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    tmr_inc  = sat_inc(tmr_q);
    sh_clear = 1'b0;
    sh_shift = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.time_button) begin
          state_d = ST_IDLE;
        end else if (bus.alarm_button) begin
          state_d = ST_SHOW_ALARM;
          tmr_d   = '0;
        end else if (key_digit) begin
          sh_clear = 1'b1;
          sh_shift = 1'b1;
          tmr_d    = '0;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (bus.time_button || bus.alarm_button) begin
          if (!valid) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = bus.time_button ? ST_LOAD_TIME : ST_LOAD_ALARM;
          end
        end else if (key_digit) begin
          sh_shift = 1'b1;
          tmr_d    = '0;
        end else if (bus.one_second) begin
          tmr_d = tmr_inc;
          if (tmr_inc == CNT_MAX) state_d = ST_IDLE;
        end
      end
      ST_SHOW_ALARM: begin
        if (bus.time_button || bus.alarm_button) begin
          state_d = ST_IDLE;
        end else if (key_digit) begin
          sh_clear = 1'b1;
          sh_shift = 1'b1;
          tmr_d    = '0;
          state_d  = ST_ENTRY;
        end else if (bus.one_second) begin
          tmr_d = tmr_inc;
          if (tmr_inc == CNT_MAX) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    load_c_d   = (state_d == ST_LOAD_TIME);
    load_a_d   = (state_d == ST_LOAD_ALARM);
    show_new_d = (state_d == ST_ENTRY) || load_c_d || load_a_d;
    show_a_d   = (state_d == ST_SHOW_ALARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      load_c_q   <= 1'b0;
      load_a_q   <= 1'b0;
      show_new_q <= 1'b0;
      show_a_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      load_c_q   <= load_c_d;
      load_a_q   <= load_a_d;
      show_new_q <= show_new_d;
      show_a_q   <= show_a_d;
      err_q      <= err_d;
    end
  end

  assign bus.new_time_ms_hr  = digits.ms_hr;
  assign bus.new_time_ls_hr  = digits.ls_hr;
  assign bus.new_time_ms_min = digits.ms_min;
  assign bus.new_time_ls_min = digits.ls_min;
  assign bus.load_new_c      = load_c_q;
  assign bus.load_new_a      = load_a_q;
  assign bus.show_new_time   = show_new_q;
  assign bus.show_a          = show_a_q;
  assign bus.entry_err       = err_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: scripted key/button sequences with a scoreboard of
// expected commit outcomes checked whenever the DUT emits a pulse.
module tb_time_set_ctrl;

  localparam int TIMEOUT_S = 10;

  typedef struct packed {
    logic        load_c;
    logic        load_a;
    logic        err;
    logic [15:0] digits;
  } evt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] obs_digits;
  logic [15:0] exp_digits;
  evt_t        sb_q[$];
  evt_t        mon_e;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.TIMEOUT_S(TIMEOUT_S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign obs_digits = {bus.new_time_ms_hr, bus.new_time_ls_hr, bus.new_time_ms_min, bus.new_time_ls_min};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_valid(input logic [15:0] d);
    logic [3:0] h1, h0, m1, m0;
    {h1, h0, m1, m0} = d;
    return (h1 <= 2) && ((h1 == 2) ? (h0 <= 3) : (h0 <= 9)) && (m1 <= 5) && (m0 <= 9);
  endfunction

  // Any pulse must match the oldest pending expected commit outcome.
  always @(negedge clk) begin
    if (!reset && (bus.load_new_c || bus.load_new_a || bus.entry_err)) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected", {29'b0, bus.load_new_c, bus.load_new_a, bus.entry_err}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_kind", {29'b0, bus.load_new_c, bus.load_new_a, bus.entry_err},
                  {29'b0, mon_e.load_c, mon_e.load_a, mon_e.err});
        check_val("sb_digits", obs_digits, mon_e.digits);
      end
    end
  end

  task automatic drive(input logic kv, input logic [3:0] k, input logic tb, input logic ab, input logic os);
    bus.key_valid    = kv;
    bus.key          = k;
    bus.time_button  = tb;
    bus.alarm_button = ab;
    bus.one_second   = os;
    @(posedge clk);
    #1;
    bus.key_valid    = 1'b0;
    bus.key          = 4'h0;
    bus.time_button  = 1'b0;
    bus.alarm_button = 1'b0;
    bus.one_second   = 1'b0;
  endtask

  task automatic press(input logic [3:0] k, input bit fresh);
    drive(1'b1, k, 1'b0, 1'b0, 1'b0);
    if (k <= 9) exp_digits = fresh ? {12'h000, k} : {exp_digits[11:0], k};
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    press(a, 1'b1);
    press(b, 1'b0);
    press(c, 1'b0);
    press(d, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic commit(input logic tbtn, input logic abtn, input logic kv, input logic [3:0] k);
    evt_t e;
    bit   v;
    v        = ref_valid(exp_digits);
    e.load_c = tbtn && v;
    e.load_a = !tbtn && abtn && v;
    e.err    = !v;
    e.digits = exp_digits;
    sb_q.push_back(e);
    drive(kv, k, tbtn, abtn, 1'b0);
    check_val("load_c_lat", bus.load_new_c, e.load_c);
    check_val("load_a_lat", bus.load_new_a, e.load_a);
    check_val("err_lat", bus.entry_err, e.err);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_val("load_c_one_cycle", bus.load_new_c, 1'b0);
    check_val("load_a_one_cycle", bus.load_new_a, 1'b0);
    check_val("idle_after_commit", bus.show_new_time, 1'b0);
    check_val("digits_held", obs_digits, exp_digits);
  endtask

  initial begin
    reset            = 1'b1;
    bus.key_valid    = 1'b0;
    bus.key          = 4'h0;
    bus.time_button  = 1'b0;
    bus.alarm_button = 1'b0;
    bus.one_second   = 1'b0;
    exp_digits       = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_load_c", bus.load_new_c, 1'b0);
    check_val("rst_load_a", bus.load_new_a, 1'b0);
    check_val("rst_show_new", bus.show_new_time, 1'b0);
    check_val("rst_show_a", bus.show_a, 1'b0);
    check_val("rst_err", bus.entry_err, 1'b0);
    check_val("rst_digits", obs_digits, 16'h0000);
    reset = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // 12:34 committed as current time
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    check_val("entry_show_new", bus.show_new_time, 1'b1);
    check_val("entry_1234", obs_digits, 16'h1234);
    commit(1'b1, 1'b0, 1'b0, 4'h0);

    // 24:00 rejected as alarm
    enter4(4'd2, 4'd4, 4'd0, 4'd0);
    commit(1'b0, 1'b1, 1'b0, 4'h0);

    // Fifth key shifts the oldest out: 35:97, rejected
    enter4(4'd2, 4'd3, 4'd5, 4'd9);
    press(4'd7, 1'b0);
    check_val("entry_3597", obs_digits, 16'h3597);
    commit(1'b1, 1'b0, 1'b0, 4'h0);

    // Non-digit codes are ignored
    press(4'd1, 1'b1);
    press(4'd2, 1'b0);
    press(4'hB, 1'b0);
    check_val("ignore_key_b", obs_digits, 16'h0012);
    press(4'hF, 1'b0);
    press(4'd5, 1'b0);
    check_val("entry_0125", obs_digits, 16'h0125);
    commit(1'b0, 1'b1, 1'b0, 4'h0);

    // Button beats a simultaneous key: 09:59 loaded, 7 dropped
    enter4(4'd0, 4'd9, 4'd5, 4'd9);
    commit(1'b1, 1'b0, 1'b1, 4'd7);

    // time_button beats alarm_button
    enter4(4'd2, 4'd3, 4'd5, 4'd9);
    commit(1'b1, 1'b1, 1'b0, 4'h0);

    enter4(4'd2, 4'd3, 4'd0, 4'd0);
    commit(1'b0, 1'b1, 1'b0, 4'h0);

    // Alarm display entry and exits
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_val("show_a_on", bus.show_a, 1'b1);
    check_val("show_a_no_new", bus.show_new_time, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check_val("show_a_off_time", bus.show_a, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_val("show_a_off_alarm", bus.show_a, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    press(4'd3, 1'b1);
    check_val("show_a_key_exit", bus.show_a, 1'b0);
    check_val("show_a_key_entry", bus.show_new_time, 1'b1);
    check_val("show_a_key_digits", obs_digits, 16'h0003);

    // Entry timeout, with a key just before expiry restarting the count
    ticks(TIMEOUT_S - 1);
    check_val("to_pre_restart", bus.show_new_time, 1'b1);
    press(4'd4, 1'b0);
    ticks(TIMEOUT_S - 1);
    check_val("to_restarted", bus.show_new_time, 1'b1);
    ticks(1);
    check_val("to_expired", bus.show_new_time, 1'b0);
    check_val("to_digits_kept", obs_digits, 16'h0034);

    // Alarm display timeout
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    ticks(TIMEOUT_S - 1);
    check_val("sa_to_pre", bus.show_a, 1'b1);
    ticks(1);
    check_val("sa_to_expired", bus.show_a, 1'b0);

    // Key and expiring tick together: key accepted, stays in entry
    press(4'd1, 1'b1);
    ticks(TIMEOUT_S - 1);
    drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    exp_digits = {exp_digits[11:0], 4'd5};
    check_val("key_tick_stay", bus.show_new_time, 1'b1);
    check_val("key_tick_digits", obs_digits, exp_digits);
    ticks(TIMEOUT_S - 1);
    check_val("key_tick_restart", bus.show_new_time, 1'b1);
    ticks(1);
    check_val("key_tick_expire", bus.show_new_time, 1'b0);

    // Reset during LOAD_TIME aborts the load
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    bus.time_button = 1'b1;
    @(posedge clk);
    #1;
    bus.time_button = 1'b0;
    check_val("abort_pre_load", bus.load_new_c, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_val("abort_load_c", bus.load_new_c, 1'b0);
    check_val("abort_show_new", bus.show_new_time, 1'b0);
    check_val("abort_digits", obs_digits, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_val("abort_no_load", bus.load_new_c, 1'b0);

    check_val("sb_drain", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
